// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: 100 Hz prescaler, BCD mm:ss counter, lap-freeze capture and display mux.
// Optional macro STOPWATCH_SATURATE_EN: hold at 59:59 instead of wrapping.
module stopwatch_time_counter #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       count_enable,
  input  logic       lap_enable,
  input  logic [2:0] reset_up,
  output logic [3:0] disp_min_t,
  output logic [3:0] disp_min_o,
  output logic [3:0] disp_sec_t,
  output logic [3:0] disp_sec_o,
  output logic       sec_pulse,
  output logic       rollover
);

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } bcd_time_t;

  localparam logic [9:0] PRESC_MAX = 10'(TICKS_PER_SEC - 1);
  localparam logic [2:0] CODE_CLEAR = 3'd2;

  logic [9:0] presc_q, presc_d;
  bcd_time_t  live_q, live_d;
  bcd_time_t  lap_q, lap_d;
  logic       lap_active_q, lap_active_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       rollover_q, rollover_d;
  logic       clear;
  logic       tick;
  logic       at_max;
  logic       advance;
`ifdef STOPWATCH_SATURATE_EN
  logic       sat_q, sat_d;
`endif

  assign clear  = (reset_up == CODE_CLEAR);
  assign tick   = count_enable && (presc_q == PRESC_MAX);
  assign at_max = (live_q.min_t == 4'd5) && (live_q.min_o == 4'd9) &&
                  (live_q.sec_t == 4'd5) && (live_q.sec_o == 4'd9);

  always_comb begin
    presc_d      = presc_q;
    live_d       = live_q;
    lap_d        = lap_q;
    lap_active_d = lap_enable;
`ifdef STOPWATCH_SATURATE_EN
    sat_d        = sat_q;
    advance      = tick && !at_max;
    rollover_d   = tick && at_max && !sat_q;
    if (tick && at_max) sat_d = 1'b1;
`else
    advance      = tick;
    rollover_d   = tick && at_max;
`endif
    sec_pulse_d  = advance;

    if (count_enable) begin
      presc_d = (presc_q == PRESC_MAX) ? 10'd0 : presc_q + 10'd1;
    end

    // Ripple carry through the BCD digits; each digit wraps at its own limit.
    if (advance) begin
      if (live_q.sec_o == 4'd9) begin
        live_d.sec_o = 4'd0;
        if (live_q.sec_t == 4'd5) begin
          live_d.sec_t = 4'd0;
          if (live_q.min_o == 4'd9) begin
            live_d.min_o = 4'd0;
            live_d.min_t = (live_q.min_t == 4'd5) ? 4'd0 : live_q.min_t + 4'd1;
          end else begin
            live_d.min_o = live_q.min_o + 4'd1;
          end
        end else begin
          live_d.sec_t = live_q.sec_t + 4'd1;
        end
      end else begin
        live_d.sec_o = live_q.sec_o + 4'd1;
      end
    end

    // Capture uses the pre-edge live value, so a coincident tick is not seen.
    if (lap_enable && !lap_active_q) begin
      lap_d = live_q;
    end

    if (clear) begin
      presc_d      = 10'd0;
      live_d       = '0;
      lap_d        = '0;
      lap_active_d = 1'b0;
      sec_pulse_d  = 1'b0;
      rollover_d   = 1'b0;
`ifdef STOPWATCH_SATURATE_EN
      sat_d        = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= 10'd0;
      live_q       <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      sec_pulse_q  <= 1'b0;
      rollover_q   <= 1'b0;
`ifdef STOPWATCH_SATURATE_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      presc_q      <= presc_d;
      live_q       <= live_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      sec_pulse_q  <= sec_pulse_d;
      rollover_q   <= rollover_d;
`ifdef STOPWATCH_SATURATE_EN
      sat_q        <= sat_d;
`endif
    end
  end

  bcd_time_t disp;
  assign disp       = lap_active_q ? lap_q : live_q;
  assign disp_min_t = disp.min_t;
  assign disp_min_o = disp.min_o;
  assign disp_sec_t = disp.sec_t;
  assign disp_sec_o = disp.sec_o;
  assign sec_pulse  = sec_pulse_q;
  assign rollover   = rollover_q;

endmodule
